// File: rtl/fpu_div_iter.sv
// Iterative IEEE-754 divider: restoring radix-2 core producing an unrounded quotient for the normalizer.
// Define FPU_DIV_UNROLL2_EN to retire two quotient bits per cycle instead of one.
module fpu_div_iter #(
    parameter int C_MANT         = 23,
    parameter int C_EXP          = 8,
    parameter int C_MANT_PRENORM = 2*C_MANT+2,
    parameter int C_EXP_PRENORM  = C_EXP+2
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RI,
    input  logic                            Start_SI,
    input  logic                            Kill_SI,
    input  logic [C_MANT+C_EXP:0]           Operand_a_DI,
    input  logic [C_MANT+C_EXP:0]           Operand_b_DI,
    output logic                            Ready_SO,
    output logic                            Valid_SO,
    output logic [C_MANT_PRENORM-1:0]       Mant_out_DO,
    output logic signed [C_EXP_PRENORM-1:0] Exp_out_DO,
    output logic                            Sign_out_DO,
    output logic                            Special_SO,
    output logic                            Div_zero_SO,
    output logic                            Invalid_SO,
    output logic [C_MANT+C_EXP:0]           Special_res_DO
);
    localparam int W   = C_MANT + C_EXP + 1;
    localparam int MW  = C_MANT + 1;
    localparam int RW  = MW + 1;
    localparam int LZW = $clog2(MW + 1);
`ifdef FPU_DIV_UNROLL2_EN
    localparam int BPC = 2;
`else
    localparam int BPC = 1;
`endif
    localparam int N_ITER = C_MANT_PRENORM / BPC;
    localparam int QW     = C_MANT_PRENORM - BPC;
    localparam int CW     = $clog2(N_ITER);
    localparam logic signed [C_EXP_PRENORM-1:0] BIAS = C_EXP_PRENORM'((1 << (C_EXP - 1)) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, UNPACK, ITER, DONE} state_t;

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] m);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (m[i]) lzc = LZW'(MW - 1 - i);
    endfunction

    function automatic logic signed [C_EXP_PRENORM-1:0] eff_exp(input logic [C_EXP-1:0] e,
                                                               input logic [LZW-1:0] lz);
        logic [C_EXP-1:0] e1;
        e1 = (e == '0) ? C_EXP'(1) : e;
        return $signed(C_EXP_PRENORM'(e1)) - $signed(C_EXP_PRENORM'(lz));
    endfunction

    // One restoring step: {quotient bit, shifted partial remainder}.
    function automatic logic [RW:0] div_step(input logic [RW-1:0] r, input logic [MW-1:0] d);
        logic          ge;
        logic [RW-2:0] diff;
        ge   = (r >= {1'b0, d});
        diff = ge ? (RW-1)'(r - {1'b0, d}) : r[RW-2:0];
        return {ge, diff, 1'b0};
    endfunction

    // Drop the q[-1] position into the sticky bit together with the remainder.
    function automatic logic [C_MANT_PRENORM-1:0] pack_mant(input logic [C_MANT_PRENORM-1:0] q,
                                                            input logic rem_nz);
        logic [C_MANT_PRENORM-1:0] m;
        m    = {1'b0, q[C_MANT_PRENORM-1:1]};
        m[0] = m[0] | q[0] | rem_nz;
        return m;
    endfunction

    state_t                            state;
    logic [CW-1:0]                     cnt;
    logic [W-1:0]                      op_a, op_b;
    logic [RW-1:0]                     rem;
    logic [MW-1:0]                     div_m;
    logic [QW-1:0]                     quot;
    logic signed [C_EXP_PRENORM-1:0]   exp_q;

    logic                  start_acc;
    logic [C_EXP-1:0]      exp_a, exp_b;
    logic [C_MANT-1:0]     frac_a, frac_b;
    logic                  sign_ab;
    logic [MW-1:0]         mraw_a, mraw_b, mnorm_a, mnorm_b;
    logic [LZW-1:0]        lz_a, lz_b;
    logic signed [C_EXP_PRENORM-1:0] exp_calc;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic is_inv, is_special, is_dz;
    logic [W-1:0]          spec_res;

    assign start_acc = (state == IDLE) && Start_SI && !Kill_SI;
    assign exp_a     = op_a[W-2:C_MANT];
    assign exp_b     = op_b[W-2:C_MANT];
    assign frac_a    = op_a[C_MANT-1:0];
    assign frac_b    = op_b[C_MANT-1:0];
    assign sign_ab   = op_a[W-1] ^ op_b[W-1];

    assign mraw_a   = {|exp_a, frac_a};
    assign mraw_b   = {|exp_b, frac_b};
    assign lz_a     = lzc(mraw_a);
    assign lz_b     = lzc(mraw_b);
    assign mnorm_a  = mraw_a << lz_a;
    assign mnorm_b  = mraw_b << lz_b;
    assign exp_calc = eff_exp(exp_a, lz_a) - eff_exp(exp_b, lz_b) + BIAS;

    assign a_nan  = (&exp_a) && (frac_a != '0);
    assign b_nan  = (&exp_b) && (frac_b != '0);
    assign a_inf  = (&exp_a) && (frac_a == '0);
    assign b_inf  = (&exp_b) && (frac_b == '0);
    assign a_zero = (exp_a == '0) && (frac_a == '0);
    assign b_zero = (exp_b == '0) && (frac_b == '0);

    assign is_inv     = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    assign is_special = is_inv || a_inf || b_inf || a_zero || b_zero;
    assign is_dz      = !is_inv && b_zero && !a_zero && !a_inf;

    always_comb begin
        spec_res = {sign_ab, {(W-1){1'b0}}};
        if (is_inv)
            spec_res = QNAN;
        else if (a_inf || b_zero)
            spec_res = {sign_ab, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    end

    logic [RW:0]               step1;
    logic [RW-1:0]             rem_nxt;
    logic [C_MANT_PRENORM-1:0] quot_nxt;
`ifdef FPU_DIV_UNROLL2_EN
    logic [RW:0]               step2;
`endif

    always_comb begin
        step1    = div_step(rem, div_m);
`ifdef FPU_DIV_UNROLL2_EN
        step2    = div_step(step1[RW-1:0], div_m);
        rem_nxt  = step2[RW-1:0];
        quot_nxt = {quot, step1[RW], step2[RW]};
`else
        rem_nxt  = step1[RW-1:0];
        quot_nxt = {quot, step1[RW]};
`endif
    end

    always_ff @(posedge Clk_CI) begin
        if (start_acc) begin
            op_a <= Operand_a_DI;
            op_b <= Operand_b_DI;
        end
        case (state)
            UNPACK: begin
                rem   <= {1'b0, mnorm_a};
                div_m <= mnorm_b;
                quot  <= '0;
                exp_q <= exp_calc;
            end
            ITER: begin
                rem  <= rem_nxt;
                quot <= quot_nxt[QW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state          <= IDLE;
            cnt            <= '0;
            Ready_SO       <= 1'b1;
            Valid_SO       <= 1'b0;
            Mant_out_DO    <= '0;
            Exp_out_DO     <= '0;
            Sign_out_DO    <= 1'b0;
            Special_SO     <= 1'b0;
            Div_zero_SO    <= 1'b0;
            Invalid_SO     <= 1'b0;
            Special_res_DO <= '0;
        end else if (Kill_SI) begin
            state    <= IDLE;
            Ready_SO <= 1'b1;
            Valid_SO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start_SI) begin
                        state    <= UNPACK;
                        Ready_SO <= 1'b0;
                    end
                end
                UNPACK: begin
                    if (is_special) begin
                        state          <= DONE;
                        Valid_SO       <= 1'b1;
                        Mant_out_DO    <= '0;
                        Exp_out_DO     <= '0;
                        Sign_out_DO    <= sign_ab;
                        Special_SO     <= 1'b1;
                        Div_zero_SO    <= is_dz;
                        Invalid_SO     <= is_inv;
                        Special_res_DO <= spec_res;
                    end else begin
                        state <= ITER;
                        cnt   <= CW'(N_ITER - 1);
                    end
                end
                ITER: begin
                    if (cnt == '0) begin
                        state          <= DONE;
                        Valid_SO       <= 1'b1;
                        Mant_out_DO    <= pack_mant(quot_nxt, rem_nxt != '0);
                        Exp_out_DO     <= exp_q;
                        Sign_out_DO    <= sign_ab;
                        Special_SO     <= 1'b0;
                        Div_zero_SO    <= 1'b0;
                        Invalid_SO     <= 1'b0;
                        Special_res_DO <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    Valid_SO <= 1'b0;
                    Ready_SO <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fpu_div_iter.md
FPU_DIV_ITER -- requirements
Module: fpu_div_iter

Interface
REQ-001 SHALL have parameter C_MANT, default 23, meaning stored mantissa bits.
REQ-002 SHALL have parameter C_EXP, default 8, meaning exponent bits; bias = 2^(C_EXP-1)-1.
REQ-003 SHALL have parameter C_MANT_PRENORM, default 2*C_MANT+2 (48), meaning output mantissa width.
REQ-004 SHALL have parameter C_EXP_PRENORM, default C_EXP+2 (10), meaning signed output exponent width.
REQ-005 SHALL have port Clk_CI, input, 1, meaning the single clock; one clock; all state on rising edge.
REQ-006 SHALL have port Rst_RI, input, 1, meaning the reset; reset is synchronous and active-high.
REQ-007 SHALL have ports Start_SI, input, 1, and Kill_SI, input, 1, meaning start and abort requests.
REQ-008 SHALL have ports Operand_a_DI and Operand_b_DI, input, C_MANT+C_EXP+1, meaning IEEE-754 dividend and divisor.
REQ-009 SHALL have ports Ready_SO and Valid_SO, output, 1, meaning idle and result-valid.
REQ-010 SHALL have ports Mant_out_DO, output, C_MANT_PRENORM; Exp_out_DO, output, C_EXP_PRENORM, signed; Sign_out_DO, output, 1; meaning the unrounded quotient in the normalizer input format.
REQ-011 SHALL have ports Special_SO, Div_zero_SO and Invalid_SO, output, 1, and Special_res_DO, output, C_MANT+C_EXP+1, meaning special-case result and flags.

Function
REQ-012 SHALL use FSM states IDLE, UNPACK, ITER, DONE; Ready_SO=1 only in IDLE; Valid_SO=1 only in DONE.
REQ-013 SHALL accept Start_SI only when Ready_SO=1 and latch both operands in that cycle (c0); Start_SI outside IDLE is ignored.
REQ-014 UNPACK (c1) SHALL form 24-bit mantissas with hidden bit = (exp!=0), treat a zero exponent field as 1, left-normalize subnormal mantissas by their leading-zero count, and decrement the effective exponent by that count.
REQ-015 UNPACK SHALL detect specials: any NaN or 0/0 or inf/inf -> Invalid_SO=1, Special_res_DO=0x7FC00000; finite nonzero/0 -> Div_zero_SO=1, signed infinity; inf/finite -> signed infinity; 0/nonzero or finite/inf -> signed zero; then go to DONE (Valid in c2) with Special_SO=1.
REQ-016 ITER SHALL run restoring radix-2 division, one quotient bit per cycle, 48 cycles (c2..c49), producing q[46:-1], remainder initialised to the dividend mantissa.
REQ-017 Mant_out_DO SHALL be {1'b0, q[46:0]} with bit 0 ORed with q[-1] and (final remainder != 0); bit 46 has weight 2^0.
REQ-018 Exp_out_DO SHALL be Ea_eff - Eb_eff + bias, computed signed at C_EXP_PRENORM bits without wrap; Sign_out_DO = sign_a ^ sign_b for all cases.
REQ-019 DONE SHALL last exactly one cycle (c50 normal), then IDLE; output data SHALL hold until the next accepted Start_SI.
REQ-020 Kill_SI in any state SHALL force IDLE at the next edge with no Valid_SO; Kill_SI with Start_SI in IDLE: Kill wins, no start.
REQ-021 Special_SO, Div_zero_SO, Invalid_SO SHALL be 0 for non-special divisions and hold with data.

Reset
REQ-022 Rst_RI=1 at a rising edge SHALL force IDLE, Ready_SO=1, Valid_SO=0, all data and flag outputs 0, at any state including mid-ITER.

Configuration
REQ-023 With macro FPU_DIV_UNROLL2_EN defined, ITER SHALL compute two quotient bits per cycle in 24 cycles (c2..c25) with DONE at c26; bit-exact results identical to the undefined case; without it, 48 cycles, DONE at c50.

Verification
REQ-024 0x3F800000 / 0x3F800000 -> Mant_out_DO=0x400000000000, Exp_out_DO=127, Sign 0, Valid at c50 (c26 with macro).
REQ-025 0x3F800000 / 0x40400000 -> Mant_out_DO=0x2AAAAAAAAAAB (sticky set), Exp_out_DO=126.
REQ-026 0xC0C00000 / 0x40000000 -> Mant_out_DO=0x600000000000, Exp_out_DO=128, Sign_out_DO=1.
REQ-027 0x00000001 / 0x3F800000 -> Mant_out_DO=0x400000000000, Exp_out_DO=-22.
REQ-028 0x3F800000 / 0x00000000 -> Special_SO=1, Div_zero_SO=1, Special_res_DO=0x7F800000 at c2; 0/0 -> Invalid_SO=1, 0x7FC00000.
REQ-029 Kill_SI at c10 -> no Valid_SO, Ready_SO=1 at c11; next Start_SI completes normally; Rst_RI at c20 -> same recovery.
